// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: port A, port B and memory command signals of the data memory arbiter
interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
);
   logic                    a_req, a_we, a_gnt, a_rvalid;
   logic [DATA_WIDTH/8-1:0] a_be;
   logic [ADDR_WIDTH-1:0]   a_addr;
   logic [DATA_WIDTH-1:0]   a_wdata, a_rdata;
   logic                    b_req, b_we, b_lock, b_gnt, b_rvalid;
   logic [DATA_WIDTH/8-1:0] b_be;
   logic [ADDR_WIDTH-1:0]   b_addr;
   logic [DATA_WIDTH-1:0]   b_wdata, b_rdata;
   logic                    mem_en, mem_we;
   logic [DATA_WIDTH/8-1:0] mem_be;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata, mem_rdata;
   modport slave (
      input  a_req, a_we, a_be, a_addr, a_wdata,
      input  b_req, b_we, b_lock, b_be, b_addr, b_wdata,
      input  mem_rdata,
      output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
   modport master (
      output a_req, a_we, a_be, a_addr, a_wdata,
      output b_req, b_we, b_lock, b_be, b_addr, b_wdata,
      output mem_rdata,
      input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for the shared L1 data memory, A priority with B anti-starvation and B burst lock
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input logic           clk,
   input logic           reset_n,
   dmem_arbiter_if.slave bus
);
   localparam int BW = DATA_WIDTH / 8;
   localparam logic [3:0] MW = 4'(MAX_WAIT);
   typedef enum logic [1:0] {A_PRIO, B_FORCE, B_LOCK} state_t;
   state_t                state;
   logic [3:0]            wait_cnt, wait_nxt;
   logic                  a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
   logic [BW-1:0]         mem_be;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   // Grant selection, command mux and next wait count; nothing is granted while reset is held
   always_comb begin
      b_gnt     = reset_n & bus.b_req & ((state != A_PRIO) | ~bus.a_req);
      a_gnt     = reset_n & bus.a_req & ~b_gnt;
      mem_we    = a_gnt ? bus.a_we : b_gnt & bus.b_we;
      mem_be    = a_gnt ? bus.a_be : b_gnt ? bus.b_be : '0;
      mem_addr  = a_gnt ? bus.a_addr : b_gnt ? bus.b_addr : '0;
      mem_wdata = a_gnt ? bus.a_wdata : b_gnt ? bus.b_wdata : '0;
      wait_nxt  = b_gnt ? 4'd0 : (bus.b_req && wait_cnt != MW) ? wait_cnt + 4'd1 : wait_cnt;
   end
   // FSM, B starvation counter and per-port read-valid flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= A_PRIO;
         wait_cnt <= '0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
      end else begin
         state    <= (b_gnt & bus.b_lock) ? B_LOCK : (state == A_PRIO && wait_nxt == MW) ? B_FORCE : A_PRIO;
         wait_cnt <= wait_nxt;
         a_rvalid <= a_gnt & ~bus.a_we;
         b_rvalid <= b_gnt & ~bus.b_we;
      end
   end
   assign bus.a_gnt     = a_gnt;
   assign bus.b_gnt     = b_gnt;
   assign bus.a_rvalid  = a_rvalid;
   assign bus.b_rvalid  = b_rvalid;
   assign bus.a_rdata   = a_rvalid ? bus.mem_rdata : '0;
   assign bus.b_rdata   = b_rvalid ? bus.mem_rdata : '0;
   assign bus.mem_en    = a_gnt | b_gnt;
   assign bus.mem_we    = mem_we;
   assign bus.mem_be    = mem_be;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a byte-enabled memory model
module tb_dmem_arbiter;
   localparam int AW = 13;
   localparam int DW = 32;
   localparam int MW = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] mem [0:8191];
   logic [31:0] shadow [0:15];
   always #5 clk = ~clk;
   dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
      for (int i = 0; i < 4; i++)
         if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
      return old;
   endfunction
   // Synchronous memory: reads return data one cycle after the command
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] = merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_be);
         else bus.mem_rdata <= mem[bus.mem_addr];
      end
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {bus.a_gnt, bus.b_gnt, bus.mem_en, bus.mem_we, bus.a_rvalid, bus.b_rvalid, bus.mem_be}, 0);
      chk({tag, "_cmd"}, {bus.mem_addr, bus.mem_wdata}, 0);
      chk({tag, "_rd"}, {bus.a_rdata, bus.b_rdata}, 0);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic set_a(input logic req, input logic we, input logic [12:0] addr, input logic [31:0] wd, input logic [3:0] be);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_be = be;
   endtask
   task automatic set_b(input logic req, input logic we, input logic lock, input logic [12:0] addr, input logic [31:0] wd, input logic [3:0] be);
      bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wd; bus.b_be = be;
   endtask
   initial begin
      logic xb, ga, gb, ra, rb;
      logic [31:0] da, db;
      int k, bw;
      logic ap, bp;
      for (int i = 0; i < 8192; i++) mem[i] = 32'hA500_0000 | i;
      mem[16] = 32'hDEAD_BEEF;
      for (int i = 0; i < 16; i++) shadow[i] = 32'hA500_0000 | i;
      // Reset: requests pending, everything must stay quiet
      set_a(1, 0, 13'h010, 0, 4'hF);
      set_b(1, 1, 1, 13'h020, 32'hFFFF_FFFF, 4'hF);
      #1 chk_zero("rst0");
      tick;
      chk_zero("rst1");
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      tick;
      reset_n = 1'b1;
      // Port A single read
      set_a(1, 0, 13'h010, 0, 4'hF);
      #1 chk("a_rd_gnt", {bus.a_gnt, bus.b_gnt}, 2'b10);
      chk("a_rd_cmd", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 13'h010});
      tick;
      set_a(0, 0, 0, 0, 0);
      chk("a_rd_rv", {bus.a_rvalid, bus.b_rvalid}, 2'b10);
      chk("a_rd_data", bus.a_rdata, 32'hDEAD_BEEF);
      chk("a_rd_bdata", bus.b_rdata, 0);
      #1 chk("a_idle", {bus.a_gnt, bus.b_gnt, bus.mem_en}, 0);
      tick;
      chk("a_rv_clr", {bus.a_rvalid, bus.a_rdata}, 0);
      // Port B partial write at top address, then read back via A
      set_b(1, 1, 0, 13'h1FFF, 32'h1234_5678, 4'b0011);
      #1 chk("b_wr_gnt", {bus.a_gnt, bus.b_gnt}, 2'b01);
      chk("b_wr_cmd", {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, {2'b11, 4'b0011, 13'h1FFF, 32'h1234_5678});
      tick;
      set_b(0, 0, 0, 0, 0, 0);
      chk("b_wr_norv", {bus.a_rvalid, bus.b_rvalid}, 0);
      set_a(1, 0, 13'h1FFF, 0, 4'hF);
      tick;
      set_a(0, 0, 0, 0, 0);
      chk("b_wr_back", {bus.a_rvalid, bus.a_rdata}, {1'b1, 32'hA500_5678});
      // Both ports request continuously: B forced every fifth cycle
      set_a(1, 0, 13'h020, 0, 4'hF);
      set_b(1, 0, 0, 13'h030, 0, 4'hF);
      for (int c = 1; c <= 10; c++) begin
         xb = (c % 5 == 0);
         #1 chk("rr_gnt", {bus.a_gnt, bus.b_gnt}, {~xb, xb});
         tick;
         chk("rr_rv", {bus.a_rvalid, bus.b_rvalid}, {~xb, xb});
         if (xb) chk("rr_bdata", bus.b_rdata, 32'hA500_0030);
      end
      // Locked B burst of 8 reads while A keeps requesting
      set_a(1, 0, 13'h040, 0, 4'hF);
      k = 0;
      for (int c = 1; c <= 14; c++) begin
         set_b(k < 8 || c == 14, 0, k < 7, 13'(32'h100 + k), 0, 4'hF);
         xb = (c >= 5 && c <= 12);
         #1 chk("lk_gnt", {bus.a_gnt, bus.b_gnt}, {~xb, xb});
         tick;
         chk("lk_rv", {bus.a_rvalid, bus.b_rvalid}, {~xb, xb});
         if (xb) begin
            chk("lk_bdata", bus.b_rdata, 32'hA500_0100 + k);
            k++;
         end
      end
      // Reset pulsed mid-burst with a read outstanding
      set_a(0, 0, 13'h010, 0, 4'hF);
      k = 0;
      for (int c = 1; c <= 3; c++) begin
         set_a(c >= 2, 0, 13'h010, 0, 4'hF);
         set_b(1, 0, 1, 13'(32'h200 + k), 0, 4'hF);
         #1 chk("mr_gnt", {bus.a_gnt, bus.b_gnt}, 2'b01);
         if (c < 3) begin
            tick;
            chk("mr_bdata", {bus.b_rvalid, bus.b_rdata}, {1'b1, 32'hA500_0200 + k});
            k++;
         end
      end
      #2 reset_n = 1'b0;
      #1 chk_zero("mr_rst0");
      tick;
      chk_zero("mr_rst1");
      reset_n = 1'b1;
      #1 chk("mr_norv", {bus.a_rvalid, bus.b_rvalid}, 0);
      chk("mr_aprio", {bus.a_gnt, bus.b_gnt}, 2'b10);
      set_a(0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      tick;
      // Random dual-port traffic against the shadow copy of addresses 0..15
      ap = 0; bp = 0; bw = 0;
      for (int c = 0; c < 300; c++) begin
         if (!ap && $urandom_range(1, 0) == 1)
            begin ap = 1; set_a(1, 1'($urandom_range(1, 0)), 13'($urandom_range(15, 0)), $urandom, 4'($urandom_range(15, 0))); end
         if (!bp && $urandom_range(1, 0) == 1)
            begin bp = 1; set_b(1, 1'($urandom_range(1, 0)), 0, 13'($urandom_range(15, 0)), $urandom, 4'($urandom_range(15, 0))); end
         bus.a_req = ap;
         bus.b_req = bp;
         #1 chk("rnd_mutex", {bus.a_gnt & bus.b_gnt}, 0);
         ga = bus.a_gnt & ap;
         gb = bus.b_gnt & bp;
         if (bp && !gb) bw++;
         if (gb) begin
            chk("rnd_bwait", {bw <= MW}, 1);
            bw = 0;
         end
         ra = 0; rb = 0; da = 0; db = 0;
         if (ga) begin
            if (bus.a_we) shadow[bus.a_addr[3:0]] = merge(shadow[bus.a_addr[3:0]], bus.a_wdata, bus.a_be);
            else begin ra = 1; da = shadow[bus.a_addr[3:0]]; end
            ap = 0;
         end
         if (gb) begin
            if (bus.b_we) shadow[bus.b_addr[3:0]] = merge(shadow[bus.b_addr[3:0]], bus.b_wdata, bus.b_be);
            else begin rb = 1; db = shadow[bus.b_addr[3:0]]; end
            bp = 0;
         end
         tick;
         chk("rnd_a", {bus.a_rvalid, bus.a_rdata}, {ra, da});
         chk("rnd_b", {bus.b_rvalid, bus.b_rdata}, {rb, db});
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
